// File: rtl/ctrl_cas_sched.sv
// CAS scheduler: in-order queue of row-opened requests, each issued as a CAS once
// tRCD has elapsed and the CAS-to-CAS / turnaround spacing to the previous CAS is met.
module ctrl_cas_sched #(
    parameter int DEPTH  = 4,
    parameter int BG_W   = 2,
    parameter int TRCD   = 11,
    parameter int TCCD_S = 4,
    parameter int TCCD_L = 6,
    parameter int TWR2RD = 14,
    parameter int TRD2WR = 9
) (
    input  logic                       CK_t,
    input  logic                       reset_n,
    input  logic                       act_valid,
    input  logic [2:0]                 act_cmd,
    input  logic [BG_W-1:0]            act_bg,
    output logic                       act_ready,
    output logic                       cas_rdy,
    output logic [2:0]                 cas_req,
    output logic [BG_W-1:0]            cas_bg,
    output logic                       cas_idle,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
    output logic                       ovf_err
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SMAX0 = (TCCD_L > TWR2RD) ? TCCD_L : TWR2RD;
    localparam int SMAX  = (SMAX0 > TRD2WR) ? SMAX0 : TRD2WR;
    localparam int SP_W  = $clog2(SMAX+1);
    localparam int AGE_W = $clog2(TRCD+1);

    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(TRCD);
    // Eligibility is decided one cycle ahead of the issue cycle, and the stored age
    // lags the push cycle by one, hence the -2.
    localparam logic [AGE_W-1:0] AGE_THR = AGE_W'((TRCD >= 2) ? TRCD - 2 : 0);
    localparam logic [SP_W-1:0]  SP_SAT  = SP_W'(SMAX);
    localparam logic [SP_W-1:0]  SP_L    = SP_W'(TCCD_L);
    localparam logic [SP_W-1:0]  SP_S    = SP_W'(TCCD_S);
    localparam logic [SP_W-1:0]  SP_W2R  = SP_W'(TWR2RD);
    localparam logic [SP_W-1:0]  SP_R2W  = SP_W'(TRD2WR);

    typedef enum logic [1:0] {CAS_IDLE, CAS_WAIT, CAS_CMD} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]         r_q_cmd [DEPTH];
    logic [BG_W-1:0]    r_q_bg  [DEPTH];
    logic [AGE_W-1:0]   r_q_age [DEPTH];
    logic [2:0]         w_q_cmd [DEPTH];
    logic [BG_W-1:0]    w_q_bg  [DEPTH];
    logic [AGE_W-1:0]   w_q_age [DEPTH];

    logic [SP_W-1:0]    r_since, w_since_nxt;
    logic               r_hist, r_last_wr;
    logic [BG_W-1:0]    r_last_bg;
    logic               r_cas_rdy, r_ovf;
    logic [2:0]         r_cas_req;
    logic [BG_W-1:0]    r_cas_bg;

    logic               w_legal, w_full, w_push, w_bad, w_pop;
    logic [IDX_W-1:0]   w_wr_idx, w_cand_idx;
    logic               w_cand_vld, w_cand_wr, w_sp_ok, w_elig;
    logic [2:0]         w_cand_cmd;
    logic [BG_W-1:0]    w_cand_bg;
    logic               w_hist_nxt, w_last_wr_nxt;
    logic [BG_W-1:0]    w_last_bg_nxt;
    logic [SP_W-1:0]    w_sp_need;

    assign w_legal   = (act_cmd >= 3'd1) && (act_cmd <= 3'd4);
    assign w_full    = (r_cnt == CNT_W'(DEPTH));
    assign w_push    = act_valid && w_legal && !w_full;
    assign w_bad     = act_valid && !(w_legal && !w_full);
    assign w_pop     = (r_state == CAS_CMD);
    assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_wr_idx  = IDX_W'(r_cnt - CNT_W'(w_pop));

    // Candidate is whichever entry will be head next cycle.
    assign w_cand_idx = IDX_W'(w_pop);
    assign w_cand_vld = (r_cnt > CNT_W'(w_pop));
    assign w_cand_cmd = r_q_cmd[w_cand_idx];
    assign w_cand_bg  = r_q_bg[w_cand_idx];
    assign w_cand_wr  = (w_cand_cmd >= 3'd3);

    assign w_hist_nxt    = r_hist | w_pop;
    assign w_last_wr_nxt = w_pop ? (r_q_cmd[0] >= 3'd3) : r_last_wr;
    assign w_last_bg_nxt = w_pop ? r_q_bg[0] : r_last_bg;
    assign w_since_nxt   = w_pop ? SP_W'(1) : ((r_since >= SP_SAT) ? r_since : r_since + SP_W'(1));
    assign w_sp_need     = (w_cand_bg == w_last_bg_nxt) ? SP_L : SP_S;

    assign w_sp_ok = !w_hist_nxt ||
                     ((w_since_nxt >= w_sp_need) &&
                      !(w_last_wr_nxt && !w_cand_wr && (w_since_nxt < SP_W2R)) &&
                      !(!w_last_wr_nxt && w_cand_wr && (w_since_nxt < SP_R2W)));
    assign w_elig  = w_cand_vld && (r_q_age[w_cand_idx] >= AGE_THR) && w_sp_ok;

    always_comb begin
        w_state_nxt = CAS_WAIT;
        if (w_cnt_nxt == '0) w_state_nxt = CAS_IDLE;
        else if (w_elig)     w_state_nxt = CAS_CMD;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_q_cmd[i] = r_q_cmd[i];
            w_q_bg[i]  = r_q_bg[i];
            w_q_age[i] = (r_q_age[i] >= AGE_SAT) ? r_q_age[i] : r_q_age[i] + AGE_W'(1);
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                w_q_cmd[i] = r_q_cmd[i+1];
                w_q_bg[i]  = r_q_bg[i+1];
                w_q_age[i] = (r_q_age[i+1] >= AGE_SAT) ? r_q_age[i+1] : r_q_age[i+1] + AGE_W'(1);
            end
        end
        if (w_push) begin
            w_q_cmd[w_wr_idx] = act_cmd;
            w_q_bg[w_wr_idx]  = act_bg;
            w_q_age[w_wr_idx] = '0;
        end
    end

    always_ff @(posedge CK_t) begin
        if (!reset_n) begin
            r_state   <= CAS_IDLE;
            r_cnt     <= '0;
            r_since   <= '0;
            r_hist    <= 1'b0;
            r_last_wr <= 1'b0;
            r_last_bg <= '0;
            r_cas_rdy <= 1'b0;
            r_cas_req <= '0;
            r_cas_bg  <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_cmd[i] <= '0;
                r_q_bg[i]  <= '0;
                r_q_age[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_since   <= w_since_nxt;
            r_hist    <= w_hist_nxt;
            r_last_wr <= w_last_wr_nxt;
            r_last_bg <= w_last_bg_nxt;
            r_cas_rdy <= (w_state_nxt == CAS_CMD);
            if (w_state_nxt == CAS_CMD) begin
                r_cas_req <= w_cand_cmd;
                r_cas_bg  <= w_cand_bg;
            end
            if (w_bad) r_ovf <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_cmd[i] <= w_q_cmd[i];
                r_q_bg[i]  <= w_q_bg[i];
                r_q_age[i] <= w_q_age[i];
            end
        end
    end

    assign act_ready = !w_full;
    assign cas_rdy   = r_cas_rdy;
    assign cas_req   = r_cas_req;
    assign cas_bg    = r_cas_bg;
    assign cas_idle  = (r_state == CAS_IDLE) && (r_cnt == '0);
    assign pend_cnt  = r_cnt;
    assign ovf_err   = r_ovf;

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// Bench for ctrl_cas_sched: directed timing scenarios plus random traffic, all
// compared cycle by cycle against a queue-based timing model.
module tb_ctrl_cas_sched;
    localparam int DEPTH = 4, BG_W = 2, TRCD = 11, TCCD_S = 4, TCCD_L = 6;
    localparam int TWR2RD = 14, TRD2WR = 9;

    logic                       CK_t = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       act_valid = 1'b0;
    logic [2:0]                 act_cmd = '0;
    logic [BG_W-1:0]            act_bg = '0;
    logic                       act_ready, cas_rdy, cas_idle, ovf_err;
    logic [2:0]                 cas_req;
    logic [BG_W-1:0]            cas_bg;
    logic [$clog2(DEPTH+1)-1:0] pend_cnt;

    ctrl_cas_sched #(.DEPTH(DEPTH), .BG_W(BG_W), .TRCD(TRCD), .TCCD_S(TCCD_S),
                     .TCCD_L(TCCD_L), .TWR2RD(TWR2RD), .TRD2WR(TRD2WR)) dut (
        .CK_t(CK_t), .reset_n(reset_n), .act_valid(act_valid), .act_cmd(act_cmd),
        .act_bg(act_bg), .act_ready(act_ready), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .cas_bg(cas_bg), .cas_idle(cas_idle), .pend_cnt(pend_cnt), .ovf_err(ovf_err));

    always #5 CK_t = ~CK_t;

    typedef struct {logic [2:0] cmd; logic [BG_W-1:0] bg; int pc;} ent_t;

    ent_t            mq[$];
    int              act_iss[$];
    int              cyc = 0, n_chk = 0, n_fail = 0;
    bit              m_hist = 0, m_lastwr = 0, m_ovf = 0;
    int              m_last = 0;
    logic [BG_W-1:0] m_lastbg = '0, m_bg = '0;
    logic [2:0]      m_req = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Head may issue at cycle c if tRCD has elapsed since its push and every
    // spacing rule relative to the previous CAS holds.
    function automatic bit m_elig(input int c);
        int d;
        bit wr;
        if (mq.size() == 0) return 0;
        if (c - mq[0].pc < TRCD) return 0;
        if (!m_hist) return 1;
        d  = c - m_last;
        wr = (mq[0].cmd >= 3);
        if (mq[0].bg == m_lastbg ? d < TCCD_L : d < TCCD_S) return 0;
        if (m_lastwr && !wr && d < TWR2RD) return 0;
        if (!m_lastwr && wr && d < TRD2WR) return 0;
        return 1;
    endfunction

    task automatic step(input bit v, input logic [2:0] cmd, input logic [BG_W-1:0] bg, input bit rn);
        bit e_rdy;
        int e_sz;
        @(posedge CK_t);
        #1;
        act_valid = v; act_cmd = cmd; act_bg = bg; reset_n = rn;
        @(negedge CK_t);
        e_rdy = m_elig(cyc);
        e_sz  = mq.size();
        if (e_rdy) begin
            m_req = mq[0].cmd;
            m_bg  = mq[0].bg;
        end
        chk("cas_rdy", 32'(cas_rdy), 32'(e_rdy));
        chk("cas_req", 32'(cas_req), 32'(m_req));
        chk("cas_bg", 32'(cas_bg), 32'(m_bg));
        chk("pend_cnt", 32'(pend_cnt), 32'(e_sz));
        chk("act_ready", 32'(act_ready), 32'(e_sz < DEPTH));
        chk("cas_idle", 32'(cas_idle), 32'(e_sz == 0));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        if (cas_rdy === 1'b1) act_iss.push_back(cyc);
        if (!rn) begin
            mq.delete();
            m_hist = 0; m_lastwr = 0; m_lastbg = '0; m_req = '0; m_bg = '0; m_ovf = 0;
        end else begin
            if (e_rdy) begin
                m_hist = 1; m_last = cyc; m_lastwr = (mq[0].cmd >= 3); m_lastbg = mq[0].bg;
                void'(mq.pop_front());
            end
            if (v) begin
                if (cmd >= 1 && cmd <= 4 && e_sz < DEPTH) mq.push_back('{cmd, bg, cyc});
                else m_ovf = 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, '0, 1);
    endtask

    task automatic do_reset();
        step(0, 3'd0, '0, 0);
        act_iss.delete();
    endtask

    // Two back-to-back pushes after reset; check both issue offsets.
    task automatic pair(input string tag, input logic [2:0] c0, input logic [BG_W-1:0] b0,
                        input logic [2:0] c1, input logic [BG_W-1:0] b1, input int e0, input int e1);
        int base;
        do_reset();
        base = cyc;
        step(1, c0, b0, 1);
        step(1, c1, b1, 1);
        idle(30);
        chk({tag, "_n"}, 32'(act_iss.size()), 32'd2);
        chk({tag, "_t0"}, (act_iss.size() > 0) ? 32'(act_iss[0] - base) : 32'hFFFF_FFFF, 32'(e0));
        chk({tag, "_t1"}, (act_iss.size() > 1) ? 32'(act_iss[1] - base) : 32'hFFFF_FFFF, 32'(e1));
    endtask

    initial begin
        int base;
        repeat (2) @(posedge CK_t);

        // single RD, bg0, pushed at cycle 10 -> issue at 21
        do_reset();
        base = cyc;
        idle(10);
        step(1, 3'd1, 2'd0, 1);
        idle(15);
        chk("single_n", 32'(act_iss.size()), 32'd1);
        chk("single_t", (act_iss.size() > 0) ? 32'(act_iss[0] - base) : 32'hFFFF_FFFF, 32'd21);
        chk("single_idle", 32'(cas_idle), 32'd1);

        pair("ccd_s", 3'd1, 2'd0, 3'd1, 2'd1, 11, 15);
        pair("ccd_l", 3'd1, 2'd0, 3'd1, 2'd0, 11, 17);
        pair("wr2rd", 3'd3, 2'd0, 3'd1, 2'd1, 11, 25);
        pair("rd2wr", 3'd1, 2'd0, 3'd3, 2'd1, 11, 20);
        pair("wra_rda", 3'd4, 2'd2, 3'd2, 2'd2, 11, 25);

        // overflow: 5 consecutive pushes into a 4-deep queue
        do_reset();
        step(1, 3'd1, 2'd0, 1);
        step(1, 3'd3, 2'd1, 1);
        step(1, 3'd2, 2'd2, 1);
        step(1, 3'd4, 2'd3, 1);
        step(1, 3'd1, 2'd1, 1);
        idle(80);
        chk("ovf_pulses", 32'(act_iss.size()), 32'd4);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);

        // reset with entries queued discards them
        do_reset();
        step(1, 3'd0, 2'd0, 1);
        step(1, 3'd1, 2'd0, 1);
        step(1, 3'd3, 2'd1, 1);
        step(1, 3'd2, 2'd2, 1);
        do_reset();
        idle(30);
        chk("rst_pulses", 32'(act_iss.size()), 32'd0);
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_idle", 32'(cas_idle), 32'd1);
        chk("rst_ovf", 32'(ovf_err), 32'd0);

        // illegal codes are dropped
        do_reset();
        step(1, 3'd1, 2'd0, 1);
        step(1, 3'd0, 2'd1, 1);
        step(1, 3'd5, 2'd1, 1);
        step(1, 3'd6, 2'd2, 1);
        step(1, 3'd7, 2'd3, 1);
        chk("illegal_pend", 32'(pend_cnt), 32'd1);
        chk("illegal_ovf", 32'(ovf_err), 32'd1);
        idle(20);

        // random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit          v, rn;
            logic [2:0]  c;
            v  = ($urandom_range(0, 99) < 35);
            c  = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            rn = ($urandom_range(0, 599) != 0);
            step(v, c, 2'($urandom_range(0, 3)), rn);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
